// File: rtl/wb_regfile_pkg.sv
// Shared constants and the write-back result select encoding for the
// wb_regfile block.
package wb_regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int ADDR_W   = 5;
   localparam int CNT_W    = 32;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_result_mux.sv
// result_mux: combinational write-back value select (ALU, data memory,
// PC+4 or LUI immediate). Zero latency; no state.
module result_mux
   import wb_regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [1:0]      result_src_i,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic [XLEN-1:0] read_data_i,
   input  logic [XLEN-1:0] pc_plus4_i,
   input  logic [XLEN-1:0] imm_ext_i,
   output logic [XLEN-1:0] result_o
);

   result_src_e sel;

   assign sel = result_src_e'(result_src_i);

   // Pick the write-back candidate named by the select code.
   always_comb begin
      result_o = {XLEN{1'b0}};
      case (sel)
         RES_ALU: result_o = alu_result_i;
         RES_MEM: result_o = read_data_i;
         RES_PC4: result_o = pc_plus4_i;
         RES_IMM: result_o = imm_ext_i;
         default: result_o = {XLEN{1'b0}};
      endcase
   end

endmodule : result_mux

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage plus architectural register file.
// x0 is hard-wired to zero, two combinational read ports, a saturating
// count of committed writes, and synchronous active-high reset.
// Optional macro WB_REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
// When it is undefined, a read of the register being written returns the
// old contents until the edge.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              reg_write_i,
   input  logic [1:0]        result_src_i,
   input  logic [XLEN-1:0]   alu_result_i,
   input  logic [XLEN-1:0]   read_data_i,
   input  logic [XLEN-1:0]   pc_plus4_i,
   input  logic [XLEN-1:0]   imm_ext_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [ADDR_W-1:0] rs1_addr_i,
   input  logic [ADDR_W-1:0] rs2_addr_i,
   output logic [XLEN-1:0]   result_o,
   output logic [XLEN-1:0]   rd1_o,
   output logic [XLEN-1:0]   rd2_o,
   output logic [CNT_W-1:0]  wr_count_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [XLEN-1:0]  regs [NREG];
   logic [CNT_W-1:0] wr_count;
   logic             commit;
   logic             rs1_valid;
   logic             rs2_valid;

   result_mux #(
      .XLEN(XLEN)
   ) u_result_mux (
      .result_src_i (result_src_i),
      .alu_result_i (alu_result_i),
      .read_data_i  (read_data_i),
      .pc_plus4_i   (pc_plus4_i),
      .imm_ext_i    (imm_ext_i),
      .result_o     (result_o)
   );

   // A write only takes effect for a non-zero, implemented destination.
   assign commit    = reg_write_i && (rd_addr_i != 5'd0) && (32'(rd_addr_i) < NREG);
   assign rs1_valid = (rs1_addr_i != 5'd0) && (32'(rs1_addr_i) < NREG);
   assign rs2_valid = (rs2_addr_i != 5'd0) && (32'(rs2_addr_i) < NREG);

   // Register array: reset clears every entry and beats any same-edge write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= {XLEN{1'b0}};
         end
      end else if (commit) begin
         regs[rd_addr_i] <= result_o;
      end else begin
         regs[rd_addr_i] <= regs[rd_addr_i];
      end
   end

   // Committed-write counter, sticky at all-ones instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_count <= {CNT_W{1'b0}};
      end else if (commit && (wr_count != CNT_MAX)) begin
         wr_count <= wr_count + 32'd1;
      end else begin
         wr_count <= wr_count;
      end
   end

   assign wr_count_o = wr_count;

   // Read port 1: x0 and unimplemented addresses read zero; optional forward.
   always_comb begin
      rd1_o = {XLEN{1'b0}};
      if (rs1_valid) begin
         rd1_o = regs[rs1_addr_i];
      end else begin
         rd1_o = {XLEN{1'b0}};
      end
`ifdef WB_REGFILE_BYPASS_EN
      if (commit && (rs1_addr_i == rd_addr_i)) begin
         rd1_o = result_o;
      end else begin
         rd1_o = rd1_o;
      end
`endif
   end

   // Read port 2: same rules as port 1; feeds the ALU source-B mux.
   always_comb begin
      rd2_o = {XLEN{1'b0}};
      if (rs2_valid) begin
         rd2_o = regs[rs2_addr_i];
      end else begin
         rd2_o = {XLEN{1'b0}};
      end
`ifdef WB_REGFILE_BYPASS_EN
      if (commit && (rs2_addr_i == rd_addr_i)) begin
         rd2_o = result_o;
      end else begin
         rd2_o = rd2_o;
      end
`endif
   end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. Expected values are hand
// computed; the same-cycle read expectation follows WB_REGFILE_BYPASS_EN.
module tb_wb_regfile;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        reg_write_i = 1'b0;
   logic [1:0]  result_src_i = 2'b00;
   logic [31:0] alu_result_i = 32'h0;
   logic [31:0] read_data_i = 32'h0;
   logic [31:0] pc_plus4_i = 32'h0;
   logic [31:0] imm_ext_i = 32'h0;
   logic [4:0]  rd_addr_i = 5'd0;
   logic [4:0]  rs1_addr_i = 5'd0;
   logic [4:0]  rs2_addr_i = 5'd0;
   logic [31:0] result_o;
   logic [31:0] rd1_o;
   logic [31:0] rd2_o;
   logic [31:0] wr_count_o;

   int total = 0;
   int bad   = 0;

   wb_regfile dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .reg_write_i  (reg_write_i),
      .result_src_i (result_src_i),
      .alu_result_i (alu_result_i),
      .read_data_i  (read_data_i),
      .pc_plus4_i   (pc_plus4_i),
      .imm_ext_i    (imm_ext_i),
      .rd_addr_i    (rd_addr_i),
      .rs1_addr_i   (rs1_addr_i),
      .rs2_addr_i   (rs2_addr_i),
      .result_o     (result_o),
      .rd1_o        (rd1_o),
      .rd2_o        (rd2_o),
      .wr_count_o   (wr_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [31:0] same_cycle_exp;

   initial begin
`ifdef WB_REGFILE_BYPASS_EN
      same_cycle_exp = 32'hDEAD_BEEF;
`else
      same_cycle_exp = 32'h0000_0001;
`endif
      // Reset, then every register reads zero on both ports.
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      chk("reset_count", wr_count_o, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rs1_addr_i = 5'(i);
         rs2_addr_i = 5'(31 - i);
         #1;
         chk($sformatf("reset_rd1_x%0d", i), rd1_o, 32'h0);
         chk($sformatf("reset_rd2_x%0d", 31 - i), rd2_o, 32'h0);
      end

      // Write x5 from the ALU, read back.
      reg_write_i = 1'b1; rd_addr_i = 5'd5; result_src_i = 2'b00;
      alu_result_i = 32'h01C0_0F93;
      read_data_i = 32'hA5A5_5A5A; pc_plus4_i = 32'h0000_0004; imm_ext_i = 32'h1234_5000;
      #1;
      chk("mux_alu", result_o, 32'h01C0_0F93);
      tick();
      reg_write_i = 1'b0; rs1_addr_i = 5'd5;
      #1;
      chk("x5_read", rd1_o, 32'h01C0_0F93);
      chk("count_1", wr_count_o, 32'd1);

      // x0 write discarded and not counted.
      reg_write_i = 1'b1; rd_addr_i = 5'd0; result_src_i = 2'b10;
      #1;
      chk("mux_pc4", result_o, 32'h0000_0004);
      rs1_addr_i = 5'd0;
      #1;
      chk("x0_same_cycle", rd1_o, 32'h0);
      tick();
      reg_write_i = 1'b0;
      #1;
      chk("x0_read", rd1_o, 32'h0);
      chk("x0_count", wr_count_o, 32'd1);

      // Memory and immediate sources into x10, x11.
      reg_write_i = 1'b1; rd_addr_i = 5'd10; result_src_i = 2'b01;
      #1;
      chk("mux_mem", result_o, 32'hA5A5_5A5A);
      tick();
      rd_addr_i = 5'd11; result_src_i = 2'b11;
      #1;
      chk("mux_imm", result_o, 32'h1234_5000);
      tick();
      reg_write_i = 1'b0; rs1_addr_i = 5'd10; rs2_addr_i = 5'd11;
      #1;
      chk("x10_read", rd1_o, 32'hA5A5_5A5A);
      chk("x11_read", rd2_o, 32'h1234_5000);
      chk("count_3", wr_count_o, 32'd3);

      // Same-cycle read of the register being written.
      reg_write_i = 1'b1; rd_addr_i = 5'd7; result_src_i = 2'b00; alu_result_i = 32'h0000_0001;
      tick();
      alu_result_i = 32'hDEAD_BEEF; rs1_addr_i = 5'd7; rs2_addr_i = 5'd7;
      #1;
      chk("same_cycle_rd2", rd2_o, same_cycle_exp);
      chk("same_addr_both", rd1_o, same_cycle_exp);
      tick();
      reg_write_i = 1'b0;
      #1;
      chk("x7_after_edge", rd2_o, 32'hDEAD_BEEF);
      chk("count_5", wr_count_o, 32'd5);

      // reg_write_i=0 holds contents and count.
      rd_addr_i = 5'd5; alu_result_i = 32'h1234_5678; rs1_addr_i = 5'd5;
      tick();
      chk("hold_x5", rd1_o, 32'h01C0_0F93);
      chk("hold_count", wr_count_o, 32'd5);

      // Reset beats a simultaneous write; result_o stays live during reset.
      rst_i = 1'b1; reg_write_i = 1'b1; rd_addr_i = 5'd3; result_src_i = 2'b11;
      imm_ext_i = 32'h1234_5000;
      #1;
      chk("mux_in_reset", result_o, 32'h1234_5000);
      tick();
      rst_i = 1'b0; reg_write_i = 1'b0;
      #1;
      chk("rst_count", wr_count_o, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rs1_addr_i = 5'(i);
         rs2_addr_i = 5'(i);
         #1;
         chk($sformatf("rst2_rd1_x%0d", i), rd1_o, 32'h0);
         chk($sformatf("rst2_rd2_x%0d", i), rd2_o, 32'h0);
      end

      // Counter saturation from a preloaded near-max value.
      @(negedge clk_i);
      force dut.wr_count = 32'hFFFF_FFFE;
      #1;
      release dut.wr_count;
      #1;
      chk("preload_count", wr_count_o, 32'hFFFF_FFFE);
      reg_write_i = 1'b1; rd_addr_i = 5'd9; result_src_i = 2'b00; alu_result_i = 32'h0000_0099;
      tick();
      chk("sat_first", wr_count_o, 32'hFFFF_FFFF);
      tick();
      chk("sat_second", wr_count_o, 32'hFFFF_FFFF);
      reg_write_i = 1'b0; rs1_addr_i = 5'd9;
      #1;
      chk("x9_read", rd1_o, 32'h0000_0099);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_wb_regfile
